// File: rtl/mac_result_drain.sv
// Snapshots NUM_PE PE accumulators on acc_done and streams them out over valid/ready.
// Optional arg-max class report at the end of each drain: define MAC_DRAIN_ARGMAX_EN.
module mac_result_drain #(
    parameter int NUM_PE = 10,
    parameter int DW     = 32,
    parameter int IDXW   = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 acc_done,
    input  logic [NUM_PE*DW-1:0] p_flat,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [DW-1:0]        out_data,
    output logic [IDXW-1:0]      out_idx,
    output logic                 out_last,
    output logic                 busy,
    output logic                 overrun
`ifdef MAC_DRAIN_ARGMAX_EN
    ,
    output logic                 class_valid,
    output logic [IDXW-1:0]      class_idx,
    output logic [DW-1:0]        class_max
`endif
);

    typedef enum logic {IDLE, SEND} state_t;

    localparam logic [IDXW-1:0] LAST = IDXW'(NUM_PE - 1);

    state_t          state_q;
    logic [DW-1:0]   shadow_q [NUM_PE];
    logic [IDXW-1:0] idx_q;
    logic [DW-1:0]   data_q;
    logic            valid_q;
    logic            last_q;
    logic            busy_q;
    logic            overrun_q;

    logic            hs;
    logic            at_last;
    logic [IDXW-1:0] nxt_idx;

    assign hs      = valid_q & out_ready;
    assign at_last = (idx_q == LAST);
    assign nxt_idx = idx_q + 1'b1;

`ifdef MAC_DRAIN_ARGMAX_EN
    logic [DW-1:0]   max_q;
    logic [IDXW-1:0] maxidx_q;
    logic            cls_valid_q;
    logic [IDXW-1:0] cls_idx_q;
    logic [DW-1:0]   cls_max_q;
    logic [DW-1:0]   max_d;
    logic [IDXW-1:0] maxidx_d;

    // Word 0 seeds the running max; strict > keeps the lowest index on ties.
    always_comb begin
        max_d    = max_q;
        maxidx_d = maxidx_q;
        if (idx_q == '0 || $signed(data_q) > $signed(max_q)) begin
            max_d    = data_q;
            maxidx_d = idx_q;
        end
    end
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            idx_q     <= '0;
            data_q    <= '0;
            valid_q   <= 1'b0;
            last_q    <= 1'b0;
            busy_q    <= 1'b0;
            overrun_q <= 1'b0;
            for (int k = 0; k < NUM_PE; k++) begin
                shadow_q[k] <= '0;
            end
`ifdef MAC_DRAIN_ARGMAX_EN
            max_q       <= '0;
            maxidx_q    <= '0;
            cls_valid_q <= 1'b0;
            cls_idx_q   <= '0;
            cls_max_q   <= '0;
`endif
        end else begin
`ifdef MAC_DRAIN_ARGMAX_EN
            cls_valid_q <= 1'b0;
`endif
            case (state_q)
                IDLE: begin
                    if (acc_done) begin
                        for (int k = 0; k < NUM_PE; k++) begin
                            shadow_q[k] <= p_flat[k*DW +: DW];
                        end
                        data_q  <= p_flat[DW-1:0];
                        idx_q   <= '0;
                        last_q  <= (NUM_PE == 1);
                        valid_q <= 1'b1;
                        busy_q  <= 1'b1;
                        state_q <= SEND;
                    end
                end
                SEND: begin
                    if (acc_done) begin
                        overrun_q <= 1'b1;
                    end
                    if (hs) begin
`ifdef MAC_DRAIN_ARGMAX_EN
                        max_q    <= max_d;
                        maxidx_q <= maxidx_d;
`endif
                        if (at_last) begin
                            idx_q   <= '0;
                            last_q  <= 1'b0;
                            valid_q <= 1'b0;
                            busy_q  <= 1'b0;
                            state_q <= IDLE;
`ifdef MAC_DRAIN_ARGMAX_EN
                            cls_valid_q <= 1'b1;
                            cls_idx_q   <= maxidx_d;
                            cls_max_q   <= max_d;
`endif
                        end else begin
                            idx_q  <= nxt_idx;
                            data_q <= shadow_q[nxt_idx];
                            last_q <= (nxt_idx == LAST);
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign out_valid = valid_q;
    assign out_data  = data_q;
    assign out_idx   = idx_q;
    assign out_last  = last_q;
    assign busy      = busy_q;
    assign overrun   = overrun_q;

`ifdef MAC_DRAIN_ARGMAX_EN
    assign class_valid = cls_valid_q;
    assign class_idx   = cls_idx_q;
    assign class_max   = cls_max_q;
`endif

endmodule

// File: doc/mac_result_drain.md
Name: mac_result_drain

Overview:
- Read-side companion to the systolic-array processing elements (PEs).
- When the controller signals that accumulation is complete, the block snapshots all NUM_PE accumulator outputs in one cycle.
- It then streams them out one word per handshake over a valid/ready interface to the downstream classifier or host bus.
- With the optional feature, it also reports the arg-max class (MNIST digit) at the end of each drain.

Parameters:
- NUM_PE, 10, number of PE accumulators captured per drain (one per output class).
- DW, 32, width of each PE result word.
- IDXW, 4, width of the word index; must satisfy 2**IDXW >= NUM_PE.

Ports:
- clk  input  1  single clock; all logic is posedge.
- rst  input  1  synchronous, active-high reset.
- acc_done  input  1  one-cycle pulse: PE accumulators are frozen and valid.
- p_flat  input  NUM_PE*DW  concatenated PE results; PE k occupies bits [k*DW +: DW].
- out_valid  output  1  out_data/out_idx/out_last are valid.
- out_ready  input  1  downstream accepts the word when high together with out_valid.
- out_data  output  DW  captured result of PE out_idx.
- out_idx  output  IDXW  index of the current word, 0..NUM_PE-1.
- out_last  output  1  high when out_idx == NUM_PE-1.
- busy  output  1  high in SEND.
- overrun  output  1  sticky: acc_done arrived while busy; cleared only by rst.

Behaviour:
- States: IDLE, SEND.
- Reset (rst high at a posedge, from any state): state=IDLE; out_valid=0, out_idx=0, out_last=0, busy=0, overrun=0, out_data=0; shadow registers cleared to 0. A drain in progress is abandoned and no partial words are emitted afterwards.
- IDLE:
  - acc_done=1: all NUM_PE words of p_flat are latched into shadow regs on the same edge; idx=0; go to SEND.
  - acc_done=0: remain in IDLE.
- Latency: acc_done sampled at edge T -> out_valid=1, out_idx=0 visible after edge T (valid during cycle T+1).
- SEND:
  - out_valid=1 and busy=1 throughout.
  - out_data=shadow[idx], out_idx=idx, out_last=(idx==NUM_PE-1).
  - Handshake = out_valid & out_ready at a posedge.
  - Handshake with idx<NUM_PE-1: idx increments.
  - Handshake with idx==NUM_PE-1: idx=0, go to IDLE; out_valid=0 next cycle.
  - No handshake: all outputs hold exactly (data/idx stable while stalled).
- Throughput: one word per cycle with out_ready held high; a full drain takes NUM_PE cycles. The next acc_done is accepted in the first IDLE cycle after the last handshake. There are no back-to-back drains without that IDLE cycle.
- acc_done while in SEND (including the cycle of the final handshake): ignored, shadow regs are untouched, overrun set to 1.
- p_flat is sampled only at capture; later changes on p_flat do not affect the drain.
- Data is passed through unmodified, with no truncation or sign change.

Optional Feature:
- Macro: MAC_DRAIN_ARGMAX_EN.
- Defined: adds the following outputs.
  - class_valid (output 1): one-cycle pulse the cycle after the final handshake.
  - class_idx (output IDXW): index of the largest result.
  - class_max (output DW): value of the largest result.
- Comparison is signed two's-complement.
- Ties resolve to the lowest index.
- Computed incrementally as words are handshaken: running max is seeded by word 0 and updated by a strict greater-than.
- class_idx and class_max hold until the next drain completes.
- All three outputs reset to 0.
- Abandoned drains (rst) produce no class_valid.
- Undefined: these ports and their logic are absent; the remaining behaviour is identical.

Test Plan:
- Basic drain:
  - Stimulus: NUM_PE=10, p_flat words k -> 100+k, pulse acc_done, out_ready=1.
  - Response: out_valid rises the next cycle; 10 consecutive words 100..109 with idx 0..9; out_last only on idx 9; busy drops after; overrun=0.
- Backpressure:
  - Stimulus: same data, out_ready toggling 1,0,0,1,... (low for 2 cycles after each accept).
  - Response: each word held stable while stalled; words arrive in order with no duplicates or skips.
- Capture isolation:
  - Stimulus: change p_flat to all 0xDEADBEEF one cycle after acc_done.
  - Response: drained words are still 100..109.
- Overrun:
  - Stimulus: pulse acc_done again at idx 4.
  - Response: overrun=1 and stays 1; the drain continues with the original data to idx 9; returns to IDLE with no second drain started.
- Reset mid-drain:
  - Stimulus: assert rst at idx 6.
  - Response: next cycle out_valid=0, idx=0, overrun=0; a fresh acc_done then drains the new p_flat from idx 0.
- Argmax (MAC_DRAIN_ARGMAX_EN):
  - Stimulus: words {-5, 7, 3, 42, 42, -100, 0, 41, 1, 2} (signed).
  - Response: class_valid pulses once, one cycle after the idx-9 handshake, with class_idx=3 and class_max=42.
  - Stimulus: all words = -1.
  - Response: class_idx=0, class_max=0xFFFFFFFF.
